// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential integer square root, y = floor(sqrt(x)), one result bit per cycle.
//
// Restoring digit-by-digit square root. A request is accepted only in IDLE.
// The result strobe comes WIDTH/2+1 cycles after the accepting edge. The
// y_vld cycle is itself an IDLE cycle, so a new request can be issued
// combinationally from y_vld.
//
// Parameters:
//   WIDTH     radicand width (even, >= 4); the result is WIDTH/2 bits
// Ports:
//   clk       clock, all state updates on posedge
//   rst       synchronous reset, active-high
//   x_vld     request strobe, accepted only when IDLE
//   x         radicand, unsigned, sampled on the accepting edge
//   y_vld     one-cycle result strobe
//   y         root, unsigned; holds the last result
//   busy      1 while computing (a request would be dropped)
//   drop_err  (only with ISQRT_SEQ_DROP_ERR_EN) sticky flag: a request
//             arrived while busy; cleared only by rst
//
// Build option: define ISQRT_SEQ_DROP_ERR_EN to add the drop_err port.
module isqrt_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               x_vld,
   input  logic [WIDTH-1:0]   x,
   output logic               y_vld,
   output logic [WIDTH/2-1:0] y,
   output logic               busy
`ifdef ISQRT_SEQ_DROP_ERR_EN
   ,
   output logic               drop_err
`endif
);

   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned CW   = $clog2(HALF) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(HALF - 1);
   // Highest even power of two that fits in the radicand.
   localparam logic [WIDTH-1:0] ONE_INIT = {2'b01, {(WIDTH - 2){1'b0}}};

   typedef enum logic [0:0] {StIdle, StCalc} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] root_q, root_d;
   logic [WIDTH-1:0] one_q, one_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [HALF-1:0]  y_q, y_d;
   logic             y_vld_q, y_vld_d;
   logic [WIDTH:0]   trial;

   // One extra bit on the trial value so root+one never wraps.
   assign trial = {1'b0, root_q} + {1'b0, one_q};

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      root_d  = root_q;
      one_d   = one_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      y_vld_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (x_vld) begin
               rem_d   = x;
               root_d  = '0;
               one_d   = ONE_INIT;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            if ({1'b0, rem_q} >= trial) begin
               rem_d  = rem_q - trial[WIDTH-1:0];
               root_d = (root_q >> 1) + one_q;
            end else begin
               root_d = root_q >> 1;
            end
            one_d = one_q >> 2;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               y_d     = root_d[HALF-1:0];
               y_vld_d = 1'b1;
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rem_q   <= '0;
         root_q  <= '0;
         one_q   <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         y_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         one_q   <= one_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         y_vld_q <= y_vld_d;
      end
   end

   assign busy  = (state_q == StCalc);
   assign y     = y_q;
   assign y_vld = y_vld_q;

`ifdef ISQRT_SEQ_DROP_ERR_EN
   logic drop_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_err_q <= 1'b0;
      end else if (x_vld && busy) begin
         drop_err_q <= 1'b1;
      end
   end

   assign drop_err = drop_err_q;
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq (WIDTH=32): table-driven vectors, hand-written corner
// sequences, and a random run; expected results go through a scoreboard
// queue that also carries the cycle in which each result is due.
module tb_isqrt_seq;

   localparam int unsigned WIDTH = 32;
   localparam int LAT   = 17;
   localparam int NRAND = 2000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        x_vld = 1'b0;
   logic [31:0] x = '0;
   logic        y_vld;
   logic [15:0] y;
   logic        busy;
`ifdef ISQRT_SEQ_DROP_ERR_EN
   logic        drop_err;
`endif

   isqrt_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld),
      .y     (y),
      .busy  (busy)
`ifdef ISQRT_SEQ_DROP_ERR_EN
      ,
      .drop_err (drop_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] y;
      int          due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [31:0] x;
      logic [15:0] y;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
      longint r;
      longint xv;
      xv = longint'(v);
      r  = longint'($floor($sqrt(real'(xv))));
      while (r * r > xv) r--;
      while ((r + 1) * (r + 1) <= xv) r++;
      return r[15:0];
   endfunction

   // Scoreboard monitor: every strobe must match the head entry, in its due cycle.
   always @(negedge clk) begin
      if (y_vld) begin
         if (sb.size() == 0) begin
            chk("unexpected_y_vld", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("y_value", {16'd0, y}, {16'd0, e.y});
            chk("y_latency", cyc, e.due);
         end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
         exp_t e;
         e = sb.pop_front();
         chk("missing_y_vld", 32'd0, 32'd1);
      end
   end

   // Called at a negedge; drives one request and returns at the next negedge.
   task automatic request(input logic [31:0] v, input bit expect_result);
      exp_t e;
      if (expect_result) begin
         e.y   = ref_sqrt(v);
         e.due = cyc + LAT;
         sb.push_back(e);
      end
      x     = v;
      x_vld = 1'b1;
      @(negedge clk);
      x_vld = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3 * LAT) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("wait_idle_timeout", 32'd1, 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      vec_t vecs[14];
      int   t0;
      int   nvld;
      int   issued;
      logic [31:0] v;

      vecs[0]  = '{32'd0,          16'd0};
      vecs[1]  = '{32'd1,          16'd1};
      vecs[2]  = '{32'd2,          16'd1};
      vecs[3]  = '{32'd3,          16'd1};
      vecs[4]  = '{32'd4,          16'd2};
      vecs[5]  = '{32'd15,         16'd3};
      vecs[6]  = '{32'd16,         16'd4};
      vecs[7]  = '{32'd24,         16'd4};
      vecs[8]  = '{32'd25,         16'd5};
      vecs[9]  = '{32'd999999,     16'd999};
      vecs[10] = '{32'd1000000,    16'd1000};
      vecs[11] = '{32'hFFFE0000,   16'hFFFE};
      vecs[12] = '{32'hFFFE0001,   16'hFFFF};
      vecs[13] = '{32'hFFFFFFFF,   16'hFFFF};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset_y_vld", {31'd0, y_vld}, 32'd0);
      chk("reset_y", {16'd0, y}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef ISQRT_SEQ_DROP_ERR_EN
      chk("reset_drop_err", {31'd0, drop_err}, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // x=0: busy over T+1..T+16, low in the y_vld cycle T+17.
      t0 = cyc;
      request(32'd0, 1'b1);
      for (int i = 1; i <= LAT; i++) begin
         chk("busy_window", {31'd0, busy}, (i < LAT) ? 32'd1 : 32'd0);
         if (i < LAT) @(negedge clk);
      end
      chk("busy_window_cycle", cyc, t0 + LAT);
      wait_idle();

      // Table: expected values straight from the table, not the reference model.
      for (int i = 0; i < 14; i++) begin
         exp_t e;
         e.y   = vecs[i].y;
         e.due = cyc + LAT;
         sb.push_back(e);
         request(vecs[i].x, 1'b0);
         wait_idle();
      end

      // Back-to-back: 16 then 25 issued in the y_vld cycle.
      request(32'd16, 1'b1);
      nvld = 0;
      while (!y_vld && nvld < 3 * LAT) begin
         @(negedge clk);
         nvld++;
      end
      chk("b2b_first_strobe_seen", {31'd0, y_vld}, 32'd1);
      t0 = cyc;
      request(32'd25, 1'b1);
      wait_idle();
      chk("b2b_second_after_first", cyc > t0 + LAT ? 32'd1 : 32'd0, 32'd1);

      // Request while busy is dropped; the result in flight is unaffected.
      request(32'd144, 1'b1);
      repeat (4) @(negedge clk);
      request(32'd100, 1'b0);
      chk("busy_during_drop", {31'd0, busy}, 32'd1);
`ifdef ISQRT_SEQ_DROP_ERR_EN
      chk("drop_err_set", {31'd0, drop_err}, 32'd1);
`endif
      wait_idle();
`ifdef ISQRT_SEQ_DROP_ERR_EN
      chk("drop_err_sticky", {31'd0, drop_err}, 32'd1);
`endif

      // Reset mid-calc: abort, no result.
      request(32'd200, 1'b0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_y_vld", {31'd0, y_vld}, 32'd0);
      chk("abort_y", {16'd0, y}, 32'd0);
`ifdef ISQRT_SEQ_DROP_ERR_EN
      chk("abort_drop_err", {31'd0, drop_err}, 32'd0);
`endif
      nvld = 0;
      for (int i = 0; i < LAT + 4; i++) begin
         @(negedge clk);
         if (y_vld) nvld++;
      end
      chk("abort_no_result", nvld, 0);

      // rst and x_vld together: rst wins.
      rst   = 1'b1;
      x     = 32'd49;
      x_vld = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      x_vld = 1'b0;
      chk("rst_beats_x_vld", {31'd0, busy}, 32'd0);
      @(negedge clk);

      // Random run, back-to-back, with junk strobes while busy.
      issued = 0;
      t0     = cyc;
      while (issued < NRAND && cyc < t0 + (NRAND + 4) * (LAT + 2)) begin
         @(negedge clk);
         x_vld = 1'b0;
         if (!busy) begin
            exp_t e;
            v = $urandom;
            if (issued % 7 == 0) v = (v & 32'hFFFF) * (v & 32'hFFFF);
            e.y   = ref_sqrt(v);
            e.due = cyc + LAT;
            sb.push_back(e);
            x     = v;
            x_vld = 1'b1;
            issued++;
         end else if ($urandom_range(0, 3) == 0) begin
            x     = $urandom;
            x_vld = 1'b1;
         end
      end
      @(negedge clk);
      x_vld = 1'b0;
      chk("random_all_issued", issued, NRAND);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
